// File: rtl/prog_sram_writer.sv
// Buffers program-loader write strobes in a small FIFO and replays them onto an
// asynchronous SRAM with programmable setup/strobe/hold, tracking count, checksum and overflow.
`timescale 1ns/1ps
module prog_sram_writer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP     = 1,
  parameter int unsigned WE_CYCLES = 2,
  parameter int unsigned HOLD      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] adr,
  input  logic [7:0]  data,
  input  logic        write,
  input  logic        clear,
  output logic [20:0] sram_adr,
  output logic [7:0]  sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        busy,
  output logic        overflow,
  output logic [20:0] byte_count,
  output logic [7:0]  checksum
);

  localparam int unsigned ADR_W  = 21;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   phase_cnt;
  logic [ADR_W-1:0]   fifo_adr  [DEPTH];
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_nxt;
  logic               empty, full, push, pop, drop, seq_done, busy_nxt;

  assign sram_oe_n = 1'b1;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign pop       = (state == S_IDLE) && !empty;
  assign push      = write && (!full || pop);
  assign drop      = write && full && !pop;
  assign seq_done  = (state == S_HOLD) && (phase_cnt == '0);
  assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign busy_nxt  = (count_nxt != '0) || pop || ((state != S_IDLE) && !seq_done);

  // FIFO storage needs no reset; occupancy is governed by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wr_ptr]  <= adr;
      fifo_data[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      busy  <= busy_nxt;
    end
  end

  // SRAM write sequencer; every pin is driven from a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      sram_adr    <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            sram_adr    <= fifo_adr[rd_ptr];
            sram_dq_out <= fifo_data[rd_ptr];
            sram_ce_n   <= 1'b0;
            sram_dq_oe  <= 1'b1;
            phase_cnt   <= CNT_W'(SETUP - 1);
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_cnt == '0) begin
            sram_we_n <= 1'b0;
            phase_cnt <= CNT_W'(WE_CYCLES - 1);
            state     <= S_STROBE;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (phase_cnt == '0) begin
            sram_we_n <= 1'b1;
            phase_cnt <= CNT_W'(HOLD - 1);
            state     <= S_HOLD;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (phase_cnt == '0) begin
            sram_ce_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            state      <= S_IDLE;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Commit statistics; a commit coinciding with clear lands on the cleared values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      checksum   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (seq_done) begin
        byte_count <= clear ? ADR_W'(1) : byte_count + ADR_W'(1);
        checksum   <= clear ? sram_dq_out : checksum + sram_dq_out;
      end else if (clear) begin
        byte_count <= '0;
        checksum   <= '0;
      end
      if (drop)       overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_sram_writer.sv
// Scoreboard bench for prog_sram_writer: queued expected writes are matched
// against each completed SRAM write cycle, with a count/checksum model.
`timescale 1ns/1ps
module tb_prog_sram_writer;

  localparam int unsigned EXP_CE_CYC = 4;
  localparam int unsigned EXP_WE_CYC = 2;
  localparam int unsigned EXP_WE_LEAD = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] adr;
  logic [7:0]  data;
  logic        write;
  logic        clear;
  logic [20:0] sram_adr;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;
  logic        busy, overflow;
  logic [20:0] byte_count;
  logic [7:0]  checksum;

  prog_sram_writer dut (
    .clk(clk), .reset(reset), .adr(adr), .data(data), .write(write), .clear(clear),
    .sram_adr(sram_adr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .busy(busy), .overflow(overflow), .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [20:0] adr;
    logic [7:0]  data;
  } wr_t;

  wr_t         sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [20:0] mdl_cnt = '0;
  logic [7:0]  mdl_chk = '0;
  logic        clr_pend = 1'b0;
  logic        in_wr = 1'b0;
  logic        unstable;
  logic [20:0] cap_adr;
  logic [7:0]  cap_dat;
  int          ce_cyc, we_cyc, we_lead;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: observe each SRAM write and the statistics outputs
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      sb.delete();
      in_wr    = 1'b0;
      mdl_cnt  = '0;
      mdl_chk  = '0;
      clr_pend = 1'b0;
    end else begin
      if (clr_pend) begin
        mdl_cnt = '0;
        mdl_chk = '0;
      end
      if (!sram_ce_n) begin
        if (!in_wr) begin
          in_wr    = 1'b1;
          cap_adr  = sram_adr;
          cap_dat  = sram_dq_out;
          ce_cyc   = 0;
          we_cyc   = 0;
          we_lead  = -1;
          unstable = 1'b0;
        end else if (sram_adr !== cap_adr || sram_dq_out !== cap_dat) begin
          unstable = 1'b1;
        end
        if (sram_dq_oe !== 1'b1) unstable = 1'b1;
        if (!sram_we_n) begin
          if (we_cyc == 0) we_lead = ce_cyc;
          we_cyc++;
        end
        ce_cyc++;
      end else if (in_wr) begin
        in_wr = 1'b0;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sram_adr", 32'(cap_adr), 32'(e.adr));
          check("sram_dq", 32'(cap_dat), 32'(e.data));
        end
        check("ce_cycles", 32'(ce_cyc), 32'(EXP_CE_CYC));
        check("we_cycles", 32'(we_cyc), 32'(EXP_WE_CYC));
        check("we_lead", 32'(we_lead), 32'(EXP_WE_LEAD));
        check("stable", 32'(unstable), 32'd0);
        mdl_cnt = mdl_cnt + 21'd1;
        mdl_chk = mdl_chk + cap_dat;
      end
      clr_pend = clear;
      check("byte_count", 32'(byte_count), 32'(mdl_cnt));
      check("checksum", 32'(checksum), 32'(mdl_chk));
    end
  end

  task automatic wr_cycle(input logic [20:0] a, input logic [7:0] d, input logic accept);
    wr_t e;
    @(posedge clk); #1;
    write = 1'b1; adr = a; data = d; clear = 1'b0;
    if (accept) begin
      e.adr = a; e.data = d;
      sb.push_back(e);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    write = 1'b0; clear = 1'b0;
  endtask

  task automatic clear_cycle();
    @(posedge clk); #1;
    write = 1'b0; clear = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [6:0] exp_ce, exp_we, exp_busy;
    exp_ce   = 7'b1000011;
    exp_we   = 7'b1100111;
    exp_busy = 7'b0111110;
    reset = 1'b1; write = 1'b0; clear = 1'b0; adr = '0; data = '0;

    repeat (2) @(negedge clk);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_adr", 32'(sram_adr), 32'd0);
    check("rst_dq", 32'(sram_dq_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single write: cycle-exact pin timing
    wr_cycle(21'h00123, 8'hA5, 1'b1);
    idle_cycle();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("single_ce_c%0d", k), 32'(sram_ce_n), 32'(exp_ce[k]));
      check($sformatf("single_we_c%0d", k), 32'(sram_we_n), 32'(exp_we[k]));
      check($sformatf("single_busy_c%0d", k), 32'(busy), 32'(exp_busy[k]));
      if (k >= 2 && k <= 5) begin
        check("single_adr", 32'(sram_adr), 32'h00123);
        check("single_dq", 32'(sram_dq_out), 32'hA5);
      end
    end
    check("single_count", 32'(byte_count), 32'd1);
    check("single_chk", 32'(checksum), 32'hA5);

    // Loader-rate burst
    clear_cycle();
    idle_cycle();
    for (int i = 0; i < 8; i++) begin
      wr_cycle(21'(i), 8'(i + 1), 1'b1);
      repeat (3) idle_cycle();
    end
    drain("burst");
    check("burst_ovf", 32'(overflow), 32'd0);
    check("burst_count", 32'(byte_count), 32'd8);
    check("burst_chk", 32'(checksum), 32'h24);

    // Overflow: sixth back-to-back write is dropped
    clear_cycle();
    idle_cycle();
    for (int i = 0; i < 6; i++) wr_cycle(21'(32'h100 + i), 8'(32'h10 + i), 1'(i < 5));
    idle_cycle();
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    drain("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_count", 32'(byte_count), 32'd5);
    clear_cycle();
    idle_cycle();
    @(negedge clk);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_count", 32'(byte_count), 32'd0);
    check("clr_chk", 32'(checksum), 32'd0);

    // Full FIFO with push in the pop cycle
    for (int i = 0; i < 5; i++) wr_cycle(21'(32'h200 + i), 8'(32'h30 + i), 1'b1);
    idle_cycle();
    wr_cycle(21'h002AA, 8'h5A, 1'b1);
    idle_cycle();
    drain("full_pp");
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_count", 32'(byte_count), 32'd6);

    // Clear coinciding with a commit
    wr_cycle(21'h00444, 8'h22, 1'b1);
    repeat (4) idle_cycle();
    clear_cycle();
    idle_cycle();
    @(negedge clk);
    check("clr_commit_count", 32'(byte_count), 32'd1);
    check("clr_commit_chk", 32'(checksum), 32'h22);
    drain("clr_commit");

    // Count wrap and checksum modulo
    clear_cycle();
    idle_cycle();
    @(posedge clk); #1;
    force dut.byte_count = 21'h1FFFFF;
    mdl_cnt = 21'h1FFFFF;
    @(posedge clk); #1;
    release dut.byte_count;
    for (int i = 0; i < 3; i++) wr_cycle(21'(32'h500 + i), 8'hFF, 1'b1);
    idle_cycle();
    drain("wrap");
    check("wrap_count", 32'(byte_count), 32'd2);
    check("wrap_chk", 32'(checksum), 32'hFD);

    // Asynchronous reset in the middle of the strobe
    for (int i = 0; i < 3; i++) wr_cycle(21'(32'h600 + i), 8'(32'h60 + i), 1'b1);
    idle_cycle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!sram_we_n) break;
    end
    check("strobe_seen", 32'(sram_we_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_we_n", 32'(sram_we_n), 32'd1);
    check("arst_ce_n", 32'(sram_ce_n), 32'd1);
    check("arst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(byte_count), 32'd0);
    check("arst_adr", 32'(sram_adr), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_ce_n", 32'(sram_ce_n), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
